// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side pointer bus of a clock-crossing FIFO: incoming gray write pointer,
// read handshake, and the flags/address/gray pointer produced by the read controller.
interface fifo_rd_ptr_ctrl_if #(
   parameter int unsigned AW = 8
);
   logic [AW:0]   wr_gray;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   rd_gray;
   logic          rd_ack;
   logic          rd_err;
   logic          empty;
   logic [AW:0]   rd_count;
   logic          ovf;

   modport master (
      output wr_gray, rd_en,
      input  rd_addr, rd_gray, rd_ack, rd_err, empty, rd_count, ovf
   );

   modport slave (
      input  wr_gray, rd_en,
      output rd_addr, rd_gray, rd_ack, rd_err, empty, rd_count, ovf
   );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller: synchronises the gray write pointer, keeps the
// read pointer, and produces empty/count/address plus a gray read pointer.
module fifo_rd_ptr_ctrl #(
   parameter int unsigned AW          = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                CLKRD,
   input  logic                RSTNRD,
   fifo_rd_ptr_ctrl_if.slave   bus
);

   logic [AW:0] sync_q [SYNC_STAGES];
   logic [AW:0] sync_g;
   logic [AW:0] wb;
   logic [AW:0] rd_bin;
   logic [AW:0] rd_bin_nxt;
   logic [AW:0] diff;
   logic [AW:0] rd_gray_q;
   logic [AW:0] rd_count_q;
   logic        empty_q;
   logic        ack_q;
   logic        err_q;
   logic        ovf_q;
   logic        acc;
   logic        ovf_hit;

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge CLKRD or negedge RSTNRD) begin
      if (!RSTNRD) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.wr_gray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_g = sync_q[SYNC_STAGES-1];

   always_comb begin
      wb = '0;
      for (int unsigned i = 0; i <= AW; i++) wb[i] = ^(sync_g >> i);
      acc        = bus.rd_en & ~empty_q;
      rd_bin_nxt = rd_bin + {{AW{1'b0}}, acc};
      diff       = wb - rd_bin_nxt;
      // Anything strictly above full depth means the pointers disagree.
      ovf_hit    = diff[AW] & (|diff[AW-1:0]);
   end

   always_ff @(posedge CLKRD or negedge RSTNRD) begin
      if (!RSTNRD) begin
         rd_bin     <= '0;
         rd_gray_q  <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         empty_q    <= 1'b1;
         rd_count_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         rd_bin     <= rd_bin_nxt;
         rd_gray_q  <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
         ack_q      <= acc;
         err_q      <= bus.rd_en & empty_q;
         empty_q    <= (diff == '0);
         rd_count_q <= diff;
         ovf_q      <= ovf_q | ovf_hit;
      end
   end

   assign bus.rd_addr  = rd_bin[AW-1:0];
   assign bus.rd_gray  = rd_gray_q;
   assign bus.rd_ack   = ack_q;
   assign bus.rd_err   = err_q;
   assign bus.empty    = empty_q;
   assign bus.rd_count = rd_count_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: directed scenarios plus random traffic against a
// pointer-arithmetic reference model compared every cycle.
module tb_fifo_rd_ptr_ctrl;
   localparam int AW   = 8;
   localparam int SYNC = 2;
   localparam int M    = 1 << (AW + 1);
   localparam int DEP  = 1 << AW;

   logic CLKRD  = 1'b0;
   logic RSTNRD = 1'b1;
   int   wptr   = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   fifo_rd_ptr_ctrl_if #(.AW(AW)) bus ();

   fifo_rd_ptr_ctrl #(.AW(AW), .SYNC_STAGES(SYNC)) dut (
      .CLKRD  (CLKRD),
      .RSTNRD (RSTNRD),
      .bus    (bus.slave)
   );

   always #5 CLKRD = ~CLKRD;

   assign bus.wr_gray = (AW+1)'(wptr ^ (wptr >> 1));

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: write pointer samples arrive SYNC+... edges late through a
   // delay queue; read pointer, flags and handshakes follow the pointer rules.
   int m_rd, m_count;
   bit m_empty, m_ovf, m_ack, m_err;
   int hist[$];

   always @(posedge CLKRD or negedge RSTNRD) begin
      if (!RSTNRD) begin
         m_rd    <= 0;
         m_count <= 0;
         m_empty <= 1'b1;
         m_ovf   <= 1'b0;
         m_ack   <= 1'b0;
         m_err   <= 1'b0;
         hist.delete();
      end else begin
         int wbv, acc, nxt, d;
         wbv = (hist.size() == SYNC) ? hist[0] : 0;
         hist.push_back(wptr);
         if (hist.size() > SYNC) void'(hist.pop_front());
         acc = (bus.rd_en && !m_empty) ? 1 : 0;
         nxt = (m_rd + acc) % M;
         d   = (wbv - nxt + M) % M;
         m_rd    <= nxt;
         m_count <= d;
         m_empty <= (d == 0);
         m_ovf   <= m_ovf || (d > DEP);
         m_ack   <= (acc == 1);
         m_err   <= bus.rd_en && m_empty;
      end
   end

   always @(negedge CLKRD) begin
      chk("empty",    int'(bus.empty),    int'(m_empty));
      chk("rd_count", int'(bus.rd_count), m_count);
      chk("rd_addr",  int'(bus.rd_addr),  m_rd % DEP);
      chk("rd_gray",  int'(bus.rd_gray),  m_rd ^ (m_rd >> 1));
      chk("rd_ack",   int'(bus.rd_ack),   int'(m_ack));
      chk("rd_err",   int'(bus.rd_err),   int'(m_err));
      chk("ovf",      int'(bus.ovf),      int'(m_ovf));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLKRD);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge CLKRD);
      #1 RSTNRD = 1'b0;
      bus.rd_en = 1'b0;
      repeat (3) begin
         wptr = int'($urandom_range(0, M - 1));
         tick();
      end
      wptr = 0;
      tick();
      RSTNRD = 1'b1;
   endtask

   task automatic walk_to(input int target);
      for (int k = 0; k < M && wptr != target; k++) begin
         wptr = (wptr + 1) % M;
         tick();
      end
   endtask

   initial begin
      bus.rd_en = 1'b0;
      #1 RSTNRD = 1'b0;
      repeat (3) begin
         wptr = int'($urandom_range(0, M - 1));
         tick();
      end
      chk("rst_empty", int'(bus.empty),    1);
      chk("rst_count", int'(bus.rd_count), 0);
      chk("rst_gray",  int'(bus.rd_gray),  0);
      chk("rst_addr",  int'(bus.rd_addr),  0);
      chk("rst_ovf",   int'(bus.ovf),      0);
      wptr = 0;
      tick();
      RSTNRD = 1'b1;
      tick(2);

      // Single word, including the synchroniser latency
      wptr = 1;
      tick(2);
      chk("lat_empty_still", int'(bus.empty), 1);
      tick();
      chk("single_empty", int'(bus.empty),    0);
      chk("single_count", int'(bus.rd_count), 1);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("single_ack",   int'(bus.rd_ack),   1);
      chk("single_addr",  int'(bus.rd_addr),  1);
      chk("single_gray",  int'(bus.rd_gray),  1);
      chk("single_empty2",int'(bus.empty),    1);
      chk("single_count2",int'(bus.rd_count), 0);

      // Underflow
      bus.rd_en = 1'b1;
      repeat (3) begin
         tick();
         chk("uf_err",  int'(bus.rd_err),  1);
         chk("uf_ack",  int'(bus.rd_ack),  0);
         chk("uf_addr", int'(bus.rd_addr), 1);
         chk("uf_gray", int'(bus.rd_gray), 1);
      end
      bus.rd_en = 1'b0;
      tick();

      // Full depth from rd_bin = 0
      do_reset();
      tick(2);
      walk_to(DEP);
      tick(3);
      chk("full_count", int'(bus.rd_count), DEP);
      chk("full_empty", int'(bus.empty),    0);
      chk("full_gray_in", int'(bus.wr_gray), 'h180);
      bus.rd_en = 1'b1;
      begin
         int acks = 0;
         repeat (DEP + 6) begin
            tick();
            if (bus.rd_ack) acks++;
         end
         chk("full_acks", acks, DEP);
      end
      bus.rd_en = 1'b0;
      chk("full_rgray", int'(bus.rd_gray), 'h180);
      chk("full_addr",  int'(bus.rd_addr), 0);
      chk("full_empty2",int'(bus.empty),   1);

      // Pointer wrap: bring rd_bin to 0x1FE, then write across the wrap
      bus.rd_en = 1'b1;
      walk_to('h1FE);
      tick(6);
      bus.rd_en = 1'b0;
      tick();
      chk("wrap_start_gray", int'(bus.rd_gray), 'h101);
      chk("wrap_start_addr", int'(bus.rd_addr), 'hFE);
      walk_to(2);
      tick(3);
      chk("wrap_count", int'(bus.rd_count), 4);
      bus.rd_en = 1'b1;
      tick(); chk("wrap_g1", int'(bus.rd_gray), 'h100);
      tick(); chk("wrap_g2", int'(bus.rd_gray), 'h000);
      tick(); chk("wrap_g3", int'(bus.rd_gray), 'h001);
      tick(); chk("wrap_g4", int'(bus.rd_gray), 'h003);
      bus.rd_en = 1'b0;
      chk("wrap_empty", int'(bus.empty), 1);
      tick();

      // Integrity: writer runs one word past full
      do_reset();
      tick(2);
      walk_to('h101);
      tick(3);
      chk("ovf_set", int'(bus.ovf), 1);
      bus.rd_en = 1'b1;
      tick(10);
      chk("ovf_sticky", int'(bus.ovf), 1);

      // Asynchronous reset mid-cycle
      @(posedge CLKRD);
      #3 RSTNRD = 1'b0;
      #1;
      chk("arst_empty", int'(bus.empty),    1);
      chk("arst_count", int'(bus.rd_count), 0);
      chk("arst_gray",  int'(bus.rd_gray),  0);
      chk("arst_addr",  int'(bus.rd_addr),  0);
      chk("arst_ovf",   int'(bus.ovf),      0);
      chk("arst_ack",   int'(bus.rd_ack),   0);
      bus.rd_en = 1'b0;
      wptr = 0;
      tick();
      RSTNRD = 1'b1;
      tick();

      // Random traffic, writer kept within depth using the model's read pointer
      for (int c = 0; c < 3000; c++) begin
         int dens;
         dens = (c / 500) % 3;
         bus.rd_en = ($urandom_range(0, 3) < dens + 1);
         if (((wptr - m_rd + M) % M) < DEP && $urandom_range(0, 3) < 3 - dens)
            wptr = (wptr + 1) % M;
         tick();
      end
      bus.rd_en = 1'b1;
      tick(DEP + 8);
      bus.rd_en = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
